// File: rtl/uart_pkg.sv
// Shared UART encodings: parity modes and receiver/transmitter state names.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial line synchronizer, falling-edge detect and three-sample majority voter.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic bit_clk,
    input  logic reset,
    input  logic din,
    input  logic sample_en,
    output logic din_sync,
    output logic fall,
    output logic vote
);

    logic [1:0] sync_q;
    logic       sync_prev;
    logic [1:0] samples;

    // Everything resets high so leaving reset looks like an idle line.
    always_ff @(posedge bit_clk) begin
        if (reset) begin
            sync_q    <= '1;
            sync_prev <= 1'b1;
            samples   <= '1;
        end else begin
            sync_q    <= {sync_q[0], din};
            sync_prev <= sync_q[1];
            if (sample_en)
                samples <= {samples[0], sync_q[1]};
        end
    end

    assign din_sync = sync_q[1];
    assign fall     = sync_prev & ~sync_q[1];
    // Third vote is the live sample at the decision tick.
    assign vote     = majority3(samples[1], samples[0], sync_q[1]);

endmodule

// File: rtl/uart_rx_recv_logic.sv
// UART receiver: frame FSM, tick/bit counters and data shift register.
module uart_rx_recv_logic
    import uart_pkg::*;
#(
    parameter int DATA_FRAME_WIDTH = 8,
    parameter int PARITY           = 0,
    parameter int OVERSAMPLE       = 8
) (
    input  logic                        bit_clk,
    input  logic                        reset,
    input  logic                        uart_rx_din,
    output logic [0:DATA_FRAME_WIDTH-1] uart_rx_dout,
    output logic                        uart_rx_valid,
    output logic                        uart_rx_parity_err,
    output logic                        uart_rx_frame_err,
    output logic                        uart_rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_FRAME_WIDTH > 1) ? $clog2(DATA_FRAME_WIDTH) : 1;

    localparam logic [CNT_W-1:0] TICK_S0   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_S1   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] TICK_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_FRAME_WIDTH - 1);

    uart_state_e state, state_next;

    logic [CNT_W-1:0]            cnt;
    logic [IDX_W-1:0]            bit_idx;
    logic [0:DATA_FRAME_WIDTH-1] data_sr;
    logic                        parity_bit;
    logic                        din_sync, fall, vote, sample_en;
    logic                        decide, at_last;
    logic                        par_exp, par_err_next;

    assign decide    = (cnt == TICK_DEC);
    assign at_last   = (cnt == TICK_LAST);
    assign sample_en = (state != ST_IDLE) && (state != ST_BREAK) &&
                       ((cnt == TICK_S0) || (cnt == TICK_S1));

    uart_rx_sampler u_sampler (
        .bit_clk   (bit_clk),
        .reset     (reset),
        .din       (uart_rx_din),
        .sample_en (sample_en),
        .din_sync  (din_sync),
        .fall      (fall),
        .vote      (vote)
    );

    assign par_exp      = (PARITY == int'(PAR_ODD)) ? ~(^data_sr) : ^data_sr;
    assign par_err_next = (PARITY != int'(PAR_NONE)) && (parity_bit != par_exp);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START: begin
                if (decide && vote)
                    state_next = ST_IDLE;
                else if (at_last)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (at_last && (bit_idx == IDX_LAST))
                    state_next = (PARITY != int'(PAR_NONE)) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (at_last) state_next = ST_STOP;
            // Leave STOP mid-bit so a start edge right at the bit boundary is caught.
            ST_STOP:   if (decide) state_next = vote ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (din_sync) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge bit_clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            bit_idx            <= '0;
            data_sr            <= '0;
            parity_bit         <= 1'b0;
            uart_rx_dout       <= '0;
            uart_rx_valid      <= 1'b0;
            uart_rx_parity_err <= 1'b0;
            uart_rx_frame_err  <= 1'b0;
        end else begin
            state         <= state_next;
            uart_rx_valid <= 1'b0;

            if ((state == ST_IDLE) || (state == ST_BREAK) || at_last)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (state == ST_DATA) begin
                if (decide)
                    data_sr[bit_idx] <= vote;
                if (at_last)
                    bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);
            end

            if ((state == ST_PARITY) && decide)
                parity_bit <= vote;

            if ((state == ST_STOP) && decide) begin
                uart_rx_valid      <= 1'b1;
                uart_rx_dout       <= data_sr;
                uart_rx_parity_err <= par_err_next;
                uart_rx_frame_err  <= ~vote;
            end
        end
    end

    assign uart_rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_recv_logic.sv
// Directed bench for uart_rx_recv_logic: one no-parity and one even-parity receiver on a shared line.
module tb_uart_rx_recv_logic;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b1;
    logic [0:7] dout0, dout1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [0:7] q0_data[$];
    int         q0_cyc[$];
    logic [0:7] q1_data[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_recv_logic #(.DATA_FRAME_WIDTH(8), .PARITY(0), .OVERSAMPLE(8)) dut0 (
        .bit_clk(clk), .reset(reset), .uart_rx_din(din), .uart_rx_dout(dout0),
        .uart_rx_valid(valid0), .uart_rx_parity_err(perr0), .uart_rx_frame_err(ferr0),
        .uart_rx_busy(busy0)
    );

    uart_rx_recv_logic #(.DATA_FRAME_WIDTH(8), .PARITY(1), .OVERSAMPLE(8)) dut1 (
        .bit_clk(clk), .reset(reset), .uart_rx_din(din), .uart_rx_dout(dout1),
        .uart_rx_valid(valid1), .uart_rx_parity_err(perr1), .uart_rx_frame_err(ferr1),
        .uart_rx_busy(busy1)
    );

    always @(negedge clk) begin
        if (valid0) begin
            q0_data.push_back(dout0);
            q0_cyc.push_back(cyc);
        end
        if (valid1)
            q1_data.push_back(dout1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        din = b;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [0:7] d, input logic with_par, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        din = 1'b1;
        wait_cycles(4);
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL reset_dout got %b expected %b", dout0, 8'h00); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", valid0); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL reset_perr got %b expected 0", perr0); end
        checks++; if (ferr0 !== 1'b0) begin failures++; $display("FAIL reset_ferr got %b expected 0", ferr0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy0); end
        reset = 1'b0;
        wait_cycles(4);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL post_reset_busy got %b expected 0", busy0); end
    endtask

    task automatic test_basic;
        q0_data.delete();
        send_frame(8'b10100101, 1'b0, 1'b0);
        wait_cycles(24);
        checks++; if (q0_data.size() != 1) begin failures++; $display("FAIL basic_valid_count got %0d expected 1", q0_data.size()); end
        checks++; if (dout0 !== 8'b10100101) begin failures++; $display("FAIL basic_dout got %b expected %b", dout0, 8'b10100101); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL basic_perr got %b expected 0", perr0); end
        checks++; if (ferr0 !== 1'b0) begin failures++; $display("FAIL basic_ferr got %b expected 0", ferr0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL basic_busy got %b expected 0", busy0); end
    endtask

    task automatic test_false_start;
        logic seen_busy;
        seen_busy = 1'b0;
        q0_data.delete();
        din = 1'b0;
        wait_cycles(2);
        din = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b1) begin failures++; $display("FAIL false_start_busy_seen got %b expected 1", seen_busy); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL false_start_busy_end got %b expected 0", busy0); end
        wait_cycles(16);
        checks++; if (q0_data.size() != 0) begin failures++; $display("FAIL false_start_valid_count got %0d expected 0", q0_data.size()); end
    endtask

    task automatic test_parity;
        q1_data.delete();
        send_frame(8'b11000000, 1'b1, 1'b1);
        wait_cycles(24);
        checks++; if (q1_data.size() != 1) begin failures++; $display("FAIL parity_bad_count got %0d expected 1", q1_data.size()); end
        checks++; if (dout1 !== 8'b11000000) begin failures++; $display("FAIL parity_bad_dout got %b expected %b", dout1, 8'b11000000); end
        checks++; if (perr1 !== 1'b1) begin failures++; $display("FAIL parity_bad_perr got %b expected 1", perr1); end
        checks++; if (ferr1 !== 1'b0) begin failures++; $display("FAIL parity_bad_ferr got %b expected 0", ferr1); end
        send_frame(8'b10100101, 1'b1, 1'b0);
        wait_cycles(24);
        checks++; if (q1_data.size() != 2) begin failures++; $display("FAIL parity_good_count got %0d expected 2", q1_data.size()); end
        checks++; if (dout1 !== 8'b10100101) begin failures++; $display("FAIL parity_good_dout got %b expected %b", dout1, 8'b10100101); end
        checks++; if (perr1 !== 1'b0) begin failures++; $display("FAIL parity_good_perr got %b expected 0", perr1); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL no_parity_perr got %b expected 0", perr0); end
    endtask

    task automatic test_break;
        q0_data.delete();
        din = 1'b0;
        wait_cycles(160);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL break_busy got %b expected 1", busy0); end
        din = 1'b1;
        wait_cycles(24);
        checks++; if (q0_data.size() != 1) begin failures++; $display("FAIL break_valid_count got %0d expected 1", q0_data.size()); end
        checks++; if (ferr0 !== 1'b1) begin failures++; $display("FAIL break_ferr got %b expected 1", ferr0); end
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL break_dout got %b expected %b", dout0, 8'h00); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL break_busy_end got %b expected 0", busy0); end
        send_frame(8'b00110101, 1'b0, 1'b0);
        wait_cycles(24);
        checks++; if (q0_data.size() != 2) begin failures++; $display("FAIL after_break_count got %0d expected 2", q0_data.size()); end
        checks++; if (dout0 !== 8'b00110101) begin failures++; $display("FAIL after_break_dout got %b expected %b", dout0, 8'b00110101); end
        checks++; if (ferr0 !== 1'b0) begin failures++; $display("FAIL after_break_ferr got %b expected 0", ferr0); end
    endtask

    task automatic test_back_to_back;
        q0_data.delete();
        q0_cyc.delete();
        send_frame(8'b00000001, 1'b0, 1'b0);
        send_frame(8'b11111110, 1'b0, 1'b0);
        wait_cycles(24);
        checks++; if (q0_data.size() != 2) begin failures++; $display("FAIL b2b_count got %0d expected 2", q0_data.size()); end
        if (q0_data.size() == 2) begin
            checks++; if (q0_cyc[1] - q0_cyc[0] != 80) begin failures++; $display("FAIL b2b_spacing got %0d expected 80", q0_cyc[1] - q0_cyc[0]); end
            checks++; if (q0_data[0] !== 8'b00000001) begin failures++; $display("FAIL b2b_data0 got %b expected %b", q0_data[0], 8'b00000001); end
            checks++; if (q0_data[1] !== 8'b11111110) begin failures++; $display("FAIL b2b_data1 got %b expected %b", q0_data[1], 8'b11111110); end
        end
    endtask

    task automatic test_reset_mid_frame;
        q0_data.delete();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        din = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL midrst_dout got %b expected %b", dout0, 8'h00); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b expected 0", valid0); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL midrst_perr got %b expected 0", perr0); end
        checks++; if (ferr0 !== 1'b0) begin failures++; $display("FAIL midrst_ferr got %b expected 0", ferr0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b expected 0", busy0); end
        wait_cycles(16);
        reset = 1'b0;
        wait_cycles(16);
        checks++; if (q0_data.size() != 0) begin failures++; $display("FAIL midrst_valid_count got %0d expected 0", q0_data.size()); end
        send_frame(8'b01101001, 1'b0, 1'b0);
        wait_cycles(24);
        checks++; if (q0_data.size() != 1) begin failures++; $display("FAIL midrst_next_count got %0d expected 1", q0_data.size()); end
        checks++; if (dout0 !== 8'b01101001) begin failures++; $display("FAIL midrst_next_dout got %b expected %b", dout0, 8'b01101001); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_false_start();
        test_parity();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_recv_logic.md
UART_RX_RECV_LOGIC -- requirements
Module: uart_rx_recv_logic

Interface
REQ-001 SHALL have parameter DATA_FRAME_WIDTH, default 8, number of data bits per frame (>=1).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter OVERSAMPLE, default 8, bit_clk ticks per serial bit (even, >=4).
REQ-004 SHALL have port bit_clk  input  1  sampling clock, OVERSAMPLE ticks per bit; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uart_rx_din  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port uart_rx_dout  output  [0:DATA_FRAME_WIDTH-1]  last received data word.
REQ-008 SHALL have port uart_rx_valid  output  1  one-cycle pulse, frame complete.
REQ-009 SHALL have port uart_rx_parity_err  output  1  parity mismatch, qualified by uart_rx_valid.
REQ-010 SHALL have port uart_rx_frame_err  output  1  stop bit sampled low, qualified by uart_rx_valid.
REQ-011 SHALL have port uart_rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass uart_rx_din through a 2-flop synchronizer; all decisions use the synchronized signal.
REQ-013 SHALL decide each bit by majority vote of three synchronized samples at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 within the bit; decision at OVERSAMPLE/2+1.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE -> START on synchronized high-to-low transition; tick counter cleared to 0.
REQ-016 START: voted 0 -> DATA at the bit boundary; voted 1 -> IDLE (false start, no output change).
REQ-017 DATA: DATA_FRAME_WIDTH bits; first serial data bit stored at uart_rx_dout index 0, last at index DATA_FRAME_WIDTH-1.
REQ-018 DATA -> PARITY if PARITY!=0, else -> STOP; PARITY compares voted bit to even/odd parity of data bits.
REQ-019 STOP: at the voting decision tick, update uart_rx_dout, error flags and pulse uart_rx_valid on the next cycle; then -> IDLE if stop voted 1, -> BREAK if 0.
REQ-020 Return to IDLE occurs mid-stop-bit so a following start edge is detected with no idle gap.
REQ-021 BREAK: remain until synchronized line is high, then -> IDLE; no further uart_rx_valid while in BREAK.
REQ-022 uart_rx_valid SHALL pulse exactly once per frame reaching STOP, including errored frames; data stored regardless of errors.
REQ-023 uart_rx_dout and error flags SHALL hold their values until the next uart_rx_valid.
REQ-024 uart_rx_parity_err SHALL be 0 whenever PARITY=0.

Reset
REQ-025 Reset SHALL force state IDLE, counters 0, uart_rx_dout 0, uart_rx_valid 0, both error flags 0, uart_rx_busy 0.
REQ-026 Synchronizer and vote registers SHALL reset to 1 so release of reset never creates a false start edge.
REQ-027 Reset mid-frame SHALL discard the partial frame with no uart_rx_valid pulse.

Structure
REQ-028 Parity mode encodings and state encodings SHALL live in shared package uart_pkg, reused by uart_tx_send_logic.
REQ-029 Synchronizer plus three-sample majority voter SHALL be sub-module uart_rx_sampler; the FSM, counters and shift register stay in uart_rx_recv_logic.

Verification (DATA_FRAME_WIDTH=8, OVERSAMPLE=8 unless stated)
REQ-030 PARITY=0, serial data 1,0,1,0,0,1,0,1 -> one uart_rx_valid, uart_rx_dout[0:7]=10100101, both errors 0.
REQ-031 Idle line pulsed low for 2 ticks -> no uart_rx_valid, uart_rx_busy back to 0 within one bit time.
REQ-032 PARITY=1, data 1,1,0,0,0,0,0,0 with parity bit 1 -> uart_rx_valid with uart_rx_parity_err=1, dout=11000000.
REQ-033 Line held low 20 bit times -> exactly one uart_rx_valid with uart_rx_frame_err=1; next well-formed frame after line rises received correctly.
REQ-034 Back-to-back frames 00000001 then 11111110, no idle gap -> two valids 80 cycles apart, correct data.
REQ-035 Reset asserted during 4th data bit -> all outputs 0 next cycle, no valid; following frame received correctly.
